// File: rtl/pb_ctrl_pkg.sv
// Shared definitions for the push-button step controller: FSM encodings,
// repeat-acceleration threshold and the counter-width helper.
package pb_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } pb_state_t;

    localparam int ACCEL_AFTER = 8;
    localparam int ACC_W       = $clog2(ACCEL_AFTER + 1);

    // Bits needed to count 0 .. max_cycles-1 without overflow.
    function automatic int tmr_width(input int max_cycles);
        return (max_cycles < 2) ? 1 : $clog2(max_cycles);
    endfunction

endpackage

// File: rtl/pb_channel.sv
// One button: 2-FF synchroniser, debounce, IDLE/HOLD/REPEAT FSM and timer.
// Build option PB_STEP_REPEAT_ACCEL_EN halves the repeat interval after ACCEL_AFTER repeats.
module pb_channel
    import pb_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES  = 500_000,
    parameter int HOLD_CYCLES = 25_000_000,
    parameter int RPT_CYCLES  = 5_000_000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic pb,
    input  logic lockout,
    output logic level_next,
    output logic pulse
);

    localparam int MAX_DH = (DEB_CYCLES > HOLD_CYCLES) ? DEB_CYCLES : HOLD_CYCLES;
    localparam int MAXC   = (MAX_DH > RPT_CYCLES) ? MAX_DH : RPT_CYCLES;
    localparam int TW     = tmr_width(MAXC);
    localparam logic REL  = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    logic          sync1, sync2, deb;
    logic [TW-1:0] deb_cnt, tmr, tmr_nxt, rpt_last;
    pb_state_t     state, state_nxt;
    logic          pressed, deb_flip, rise;

    assign pressed    = sync2 ^ REL;
    assign deb_flip   = (pressed != deb) && (deb_cnt == TW'(DEB_CYCLES - 1));
    assign level_next = deb ^ deb_flip;
    assign rise       = deb_flip & ~deb;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= REL;
            sync2   <= REL;
            deb     <= 1'b0;
            deb_cnt <= '0;
        end else begin
            sync1 <= pb;
            sync2 <= sync1;
            deb   <= level_next;
            if ((pressed == deb) || deb_flip)
                deb_cnt <= '0;
            else
                deb_cnt <= deb_cnt + 1'b1;
        end
    end

`ifdef PB_STEP_REPEAT_ACCEL_EN
    logic [ACC_W-1:0] rpt_cnt, rpt_cnt_nxt;
    logic             accel;

    assign accel    = (rpt_cnt == ACC_W'(ACCEL_AFTER));
    assign rpt_last = accel ? TW'(RPT_CYCLES / 2 - 1) : TW'(RPT_CYCLES - 1);

    // Counts HOLD->REPEAT and REPEAT pulses only; the initial press pulse is not a repeat.
    always_comb begin
        rpt_cnt_nxt = rpt_cnt;
        if (lockout || !level_next || (state == IDLE))
            rpt_cnt_nxt = '0;
        else if (pulse && !accel)
            rpt_cnt_nxt = rpt_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            rpt_cnt <= '0;
        else
            rpt_cnt <= rpt_cnt_nxt;
    end
`else
    assign rpt_last = TW'(RPT_CYCLES - 1);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            tmr   <= '0;
        end else begin
            state <= state_nxt;
            tmr   <= tmr_nxt;
        end
    end

    // Release and lockout win over any pending timer pulse on the same edge.
    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        pulse     = 1'b0;
        if (lockout || !level_next) begin
            state_nxt = IDLE;
            tmr_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rise) begin
                        state_nxt = HOLD;
                        tmr_nxt   = '0;
                        pulse     = 1'b1;
                    end
                end
                HOLD: begin
                    if (tmr == TW'(HOLD_CYCLES - 1)) begin
                        state_nxt = REPEAT;
                        tmr_nxt   = '0;
                        pulse     = 1'b1;
                    end else begin
                        tmr_nxt = tmr + 1'b1;
                    end
                end
                REPEAT: begin
                    if (tmr == rpt_last) begin
                        tmr_nxt = '0;
                        pulse   = 1'b1;
                    end else begin
                        tmr_nxt = tmr + 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    tmr_nxt   = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pb_step_ctrl.sv
// Two-button step front end for the PWM duty controller: lockout and output registers.
// Build option PB_STEP_REPEAT_ACCEL_EN enables repeat acceleration in each channel.
module pb_step_ctrl
    import pb_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES  = 500_000,
    parameter int HOLD_CYCLES = 25_000_000,
    parameter int RPT_CYCLES  = 5_000_000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic pb_inc,
    input  logic pb_dec,
    output logic step_inc,
    output logic step_dec,
    output logic held_inc,
    output logic held_dec
);

    logic lvl_inc, lvl_dec, pulse_inc, pulse_dec;
    logic lock, lock_nxt;

    // Lockout engages as soon as both levels are up and holds until both are down.
    assign lock_nxt = (lvl_inc & lvl_dec) | (lock & (lvl_inc | lvl_dec));

    pb_channel #(
        .DEB_CYCLES (DEB_CYCLES),
        .HOLD_CYCLES(HOLD_CYCLES),
        .RPT_CYCLES (RPT_CYCLES),
        .ACTIVE_LOW (ACTIVE_LOW)
    ) u_inc (
        .clk       (clk),
        .rst       (rst),
        .pb        (pb_inc),
        .lockout   (lock_nxt),
        .level_next(lvl_inc),
        .pulse     (pulse_inc)
    );

    pb_channel #(
        .DEB_CYCLES (DEB_CYCLES),
        .HOLD_CYCLES(HOLD_CYCLES),
        .RPT_CYCLES (RPT_CYCLES),
        .ACTIVE_LOW (ACTIVE_LOW)
    ) u_dec (
        .clk       (clk),
        .rst       (rst),
        .pb        (pb_dec),
        .lockout   (lock_nxt),
        .level_next(lvl_dec),
        .pulse     (pulse_dec)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            lock     <= 1'b0;
            held_inc <= 1'b0;
            held_dec <= 1'b0;
            step_inc <= 1'b0;
            step_dec <= 1'b0;
        end else begin
            lock     <= lock_nxt;
            held_inc <= lvl_inc;
            held_dec <= lvl_dec;
            step_inc <= pulse_inc & ~lock_nxt;
            step_dec <= pulse_dec & ~lock_nxt & ~pulse_inc;
        end
    end

endmodule

// File: tb/tb_pb_step_ctrl.sv
// Directed bench for pb_step_ctrl with DEB=4, HOLD=20, RPT=8, active-low buttons.
module tb_pb_step_ctrl;

    logic clk = 1'b0;
    logic rst, pb_inc, pb_dec;
    logic step_inc, step_dec, held_inc, held_dec;

    int checks = 0;
    int errors = 0;
    int both_cnt = 0;

    pb_step_ctrl #(
        .DEB_CYCLES (4),
        .HOLD_CYCLES(20),
        .RPT_CYCLES (8),
        .ACTIVE_LOW (1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .pb_inc  (pb_inc),
        .pb_dec  (pb_dec),
        .step_inc(step_inc),
        .step_dec(step_dec),
        .held_inc(held_inc),
        .held_dec(held_dec)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (step_inc === 1'b1 && step_dec === 1'b1) both_cnt++;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        int first, cnt, h6;
        first = -1; cnt = 0; h6 = 0;
        rst = 1'b1; pb_inc = 1'b0; pb_dec = 1'b1;
        settle(3);
        chk("reset_step_inc", int'(step_inc), 0);
        chk("reset_step_dec", int'(step_dec), 0);
        chk("reset_held_inc", int'(held_inc), 0);
        chk("reset_held_dec", int'(held_dec), 0);
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (step_inc) begin
                cnt++;
                if (first < 0) first = k;
            end
            if (k == 6) h6 = int'(held_inc);
        end
        chk("reset_first_step_cycle", first, 6);
        chk("reset_step_count", cnt, 1);
        chk("reset_held_at_6", h6, 1);
        pb_inc = 1'b1;
        settle(10);
    endtask

    task automatic test_bounce();
        int steps, helds, first;
        steps = 0; helds = 0; first = -1;
        for (int r = 0; r < 5; r++) begin
            pb_inc = 1'b0;
            for (int k = 0; k < 3; k++) begin
                tick();
                if (step_inc) steps++;
                if (held_inc) helds++;
            end
            pb_inc = 1'b1;
            for (int k = 0; k < 3; k++) begin
                tick();
                if (step_inc) steps++;
                if (held_inc) helds++;
            end
        end
        settle(4);
        chk("bounce_step_count", steps, 0);
        chk("bounce_held_count", helds, 0);
        steps = 0;
        pb_inc = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (step_inc) begin
                steps++;
                if (first < 0) first = k;
            end
            if (k == 10) pb_inc = 1'b1;
        end
        chk("press_step_count", steps, 1);
        chk("press_step_cycle", first, 6);
        chk("press_held_after_release", int'(held_inc), 0);
    endtask

    task automatic test_hold();
        int t[16];
        int exp_t[6];
        int n, inc_steps, h30;
        exp_t = '{6, 26, 34, 42, 50, 58};
        n = 0; inc_steps = 0; h30 = 0;
        pb_dec = 1'b0;
        for (int k = 1; k <= 80; k++) begin
            tick();
            if (step_dec) begin
                if (n < 16) t[n] = k;
                n++;
            end
            if (step_inc) inc_steps++;
            if (k == 30) h30 = int'(held_dec);
            if (k == 60) pb_dec = 1'b1;
        end
        chk("hold_dec_count", n, 6);
        for (int i = 0; i < 6; i++)
            chk($sformatf("hold_dec_time[%0d]", i), (i < n) ? t[i] : -1, exp_t[i]);
        chk("hold_inc_quiet", inc_steps, 0);
        chk("hold_held_mid", h30, 1);
        chk("hold_held_after", int'(held_dec), 0);
    endtask

    task automatic test_lockout();
        int ti[16];
        int ni, nd, td, hd42, hi42, early_dec;
        ni = 0; nd = 0; td = -1; hd42 = 0; hi42 = 0; early_dec = 0;
        pb_inc = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            tick();
            if (step_inc) begin
                if (ni < 16) ti[ni] = k;
                ni++;
            end
            if (step_dec) begin
                nd++;
                if (td < 0) td = k;
                if (k < 80) early_dec++;
            end
            if (k == 42) begin
                hd42 = int'(held_dec);
                hi42 = int'(held_inc);
            end
            if (k == 36) pb_dec = 1'b0;
            if (k == 50) pb_inc = 1'b1;
            if (k == 70) pb_dec = 1'b1;
            if (k == 80) pb_dec = 1'b0;
            if (k == 90) pb_dec = 1'b1;
        end
        chk("lock_inc_count", ni, 3);
        chk("lock_inc_last", (ni >= 3 && ni <= 16) ? ti[ni-1] : -1, 34);
        chk("lock_held_dec_42", hd42, 1);
        chk("lock_held_inc_42", hi42, 1);
        chk("lock_dec_while_locked", early_dec, 0);
        chk("lock_dec_count", nd, 1);
        chk("lock_dec_repress_cycle", td, 86);
    endtask

    task automatic test_reset_mid();
        int s37, s38, h37, first, cnt, pre;
        first = -1; cnt = 0; pre = 0; s37 = -1; s38 = -1; h37 = -1;
        pb_inc = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            tick();
            if (k == 37) begin
                s37 = int'(step_inc);
                h37 = int'(held_inc);
            end
            if (k == 38) s38 = int'(step_inc);
            if (step_inc && k <= 36) pre++;
            if (step_inc && k > 36) begin
                cnt++;
                if (first < 0) first = k;
            end
            if (k == 36) rst = 1'b1;
            if (k == 37) rst = 1'b0;
        end
        pb_inc = 1'b1;
        settle(10);
        chk("rstmid_pre_pulses", pre, 3);
        chk("rstmid_step_rst_cycle", s37, 0);
        chk("rstmid_step_next_cycle", s38, 0);
        chk("rstmid_held_cleared", h37, 0);
        chk("rstmid_restart_cycle", first, 43);
        chk("rstmid_restart_count", cnt, 1);
    endtask

`ifdef PB_STEP_REPEAT_ACCEL_EN
    task automatic test_accel();
        int t[64];
        int n;
        n = 0;
        pb_inc = 1'b0;
        for (int k = 1; k <= 160; k++) begin
            tick();
            if (step_inc) begin
                if (n < 64) t[n] = k;
                n++;
            end
            if (k == 150) pb_inc = 1'b1;
        end
        chk("accel_pulse8", (n > 8) ? t[8] : -1, 82);
        chk("accel_pulse9", (n > 9) ? t[9] : -1, 86);
        chk("accel_pulse10", (n > 10) ? t[10] : -1, 90);
        settle(10);
    endtask
`endif

    initial begin
        rst = 1'b1; pb_inc = 1'b1; pb_dec = 1'b1;
        test_reset();
        test_bounce();
        test_hold();
        test_lockout();
        test_reset_mid();
`ifdef PB_STEP_REPEAT_ACCEL_EN
        test_accel();
`endif
        chk("never_both_strobes", both_cnt, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
